// File: rtl/mem_access_master_if.sv
// Request/response handshake plus word-memory strobe bus for mem_access_master.
// The master modport is the initiator's view; slave is the CPU/memory side.
interface mem_access_master_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
);
    // CPU-side request channel
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // CPU-side response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    // Memory-side strobes and data
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wr;
    logic              mem_rd;
    logic              mem_rst;
    logic [DATA_W-1:0] mem_data1;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_data1,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output mem_address, mem_data, mem_wr, mem_rd, mem_rst
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_data1,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  mem_address, mem_data, mem_wr, mem_rd, mem_rst
    );
endinterface

// File: rtl/mem_access_master.sv
// Initiator for the 256x32 word memory: takes one load/store/clear request at
// a time, drives a single one-hot strobe for a fixed number of cycles and
// returns one response. Reserved ops and out-of-range addresses short-circuit
// straight to an error response without touching the memory.
module mem_access_master #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int RD_CYCLES = 1,
    parameter int WR_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    mem_access_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Counter only needs to reach the longer of the two strobe lengths minus one.
    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic              accept;
    logic              req_bad;
    logic              last_cyc;

    // Accept/error decode and next-state logic; strobes decode from the
    // registered state so an asynchronous reset removes them immediately.
    always_comb begin
        state_next = state_reg;
        accept     = bus.req_valid && (state_reg == IDLE);
        req_bad    = (bus.req_op == OP_RSVD) || ({1'b0, bus.req_addr} >= DEPTH_LIM);
        last_cyc   = (cnt_reg == ((op_reg == OP_READ) ? RD_LAST : WR_LAST));

        case (state_reg)
            IDLE:    if (accept)        state_next = req_bad ? RESP : ACCESS;
            ACCESS:  if (last_cyc)      state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase

        // Ready is held low while reset is asserted even though state is IDLE.
        bus.req_ready   = (state_reg == IDLE) && rst_n;
        bus.rsp_valid   = (state_reg == RESP);
        bus.busy        = (state_reg != IDLE);
        bus.mem_rd      = (state_reg == ACCESS) && (op_reg == OP_READ);
        bus.mem_wr      = (state_reg == ACCESS) && (op_reg == OP_WRITE);
        bus.mem_rst     = (state_reg == ACCESS) && (op_reg == OP_CLEAR);
        bus.mem_address = addr_reg;
        bus.mem_data    = wdata_reg;
        bus.rsp_rdata   = rdata_reg;
        bus.rsp_err     = err_reg;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch, strobe-length counter and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            op_reg    <= OP_READ;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            cnt_reg   <= '0;
            op_reg    <= bus.req_op;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            rdata_reg <= '0;
            err_reg   <= req_bad;
        end else if (state_reg == ACCESS) begin
            if (last_cyc) begin
                cnt_reg <= '0;
                if (op_reg == OP_READ) begin
                    rdata_reg <= bus.mem_data1;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master: one instance with single-cycle strobes
// backed by a small word memory, one with a 3-cycle read strobe driven by hand.
module tb_mem_access_master;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mem_access_master_if #(.ADDR_W(28), .DATA_W(32)) if1 ();
    mem_access_master_if #(.ADDR_W(28), .DATA_W(32)) if3 ();

    mem_access_master #(.ADDR_W(28), .DATA_W(32), .MEM_DEPTH(256),
                        .RD_CYCLES(1), .WR_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    mem_access_master #(.ADDR_W(28), .DATA_W(32), .MEM_DEPTH(256),
                        .RD_CYCLES(3), .WR_CYCLES(1)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory behind dut1
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (if1.mem_wr)       mem[if1.mem_address[7:0]] <= if1.mem_data;
        else if (if1.mem_rst) mem[if1.mem_address[7:0]] <= 32'h0;
    end
    assign if1.mem_data1 = mem[if1.mem_address[7:0]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request on dut1 (N=1), response consumed immediately.
    task automatic txn(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] wdata,
                       input bit exp_err, input logic [31:0] exp_rdata);
        chk("req_ready_idle", 32'(if1.req_ready), 32'd1);
        if1.req_valid = 1'b1;
        if1.req_op    = op;
        if1.req_addr  = addr;
        if1.req_wdata = wdata;
        step();
        if1.req_valid = 1'b0;
        if (!exp_err) begin
            chk("mem_wr_strobe",  32'(if1.mem_wr),  32'(op == 2'b01));
            chk("mem_rd_strobe",  32'(if1.mem_rd),  32'(op == 2'b00));
            chk("mem_rst_strobe", 32'(if1.mem_rst), 32'(op == 2'b10));
            chk("mem_address",    32'(if1.mem_address), 32'(addr));
            if (op == 2'b01) chk("mem_data", if1.mem_data, wdata);
            chk("rsp_valid_access", 32'(if1.rsp_valid), 32'd0);
            chk("req_ready_access", 32'(if1.req_ready), 32'd0);
            step();
        end
        chk("rsp_valid",   32'(if1.rsp_valid), 32'd1);
        chk("rsp_err",     32'(if1.rsp_err),   32'(exp_err));
        chk("rsp_rdata",   if1.rsp_rdata,      exp_rdata);
        chk("strobes_off", 32'({if1.mem_wr, if1.mem_rd, if1.mem_rst}), 32'd0);
        chk("req_ready_resp", 32'(if1.req_ready), 32'd0);
        $display("txn op=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                 op, addr, wdata, if1.rsp_rdata, if1.rsp_err);
        if1.rsp_ready = 1'b1;
        step();
        if1.rsp_ready = 1'b0;
        chk("rsp_valid_done", 32'(if1.rsp_valid), 32'd0);
        chk("busy_done",      32'(if1.busy),      32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        if1.req_valid = 1'b0; if1.req_op = 2'b00; if1.req_addr = '0; if1.req_wdata = '0;
        if1.rsp_ready = 1'b0;
        if3.req_valid = 1'b0; if3.req_op = 2'b00; if3.req_addr = '0; if3.req_wdata = '0;
        if3.rsp_ready = 1'b0; if3.mem_data1 = '0;

        // Reset values
        #2;
        chk("rst_req_ready", 32'(if1.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
        chk("rst_strobes",   32'({if1.mem_wr, if1.mem_rd, if1.mem_rst}), 32'd0);
        chk("rst_mem_addr",  32'(if1.mem_address), 32'd0);
        chk("rst_mem_data",  if1.mem_data,  32'd0);
        chk("rst_rdata",     if1.rsp_rdata, 32'd0);
        chk("rst_err",       32'(if1.rsp_err), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("req_ready_after_rst", 32'(if1.req_ready), 32'd1);
        $display("reset released");

        // Reset in the middle of a read
        step();
        if1.req_valid = 1'b1; if1.req_op = 2'b00; if1.req_addr = 28'h05;
        step();
        if1.req_valid = 1'b0;
        chk("midrd_mem_rd_before", 32'(if1.mem_rd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_mem_rd_dropped", 32'(if1.mem_rd),    32'd0);
        chk("midrd_req_ready_rst",  32'(if1.req_ready), 32'd0);
        chk("midrd_busy_rst",       32'(if1.busy),      32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midrd_req_ready_rel", 32'(if1.req_ready), 32'd1);
        step();
        chk("midrd_no_rsp1", 32'(if1.rsp_valid), 32'd0);
        step();
        chk("midrd_no_rsp2", 32'(if1.rsp_valid), 32'd0);
        $display("reset during read: request dropped");

        // Write / read back / clear / read back
        txn(2'b01, 28'h05, 32'hDEADBEEF, 1'b0, 32'h0);
        txn(2'b00, 28'h05, 32'h0,        1'b0, 32'hDEADBEEF);
        txn(2'b10, 28'h05, 32'hFFFFFFFF, 1'b0, 32'h0);
        txn(2'b00, 28'h05, 32'h0,        1'b0, 32'h0);

        // Error cases: address == depth, reserved op
        txn(2'b00, 28'h100, 32'h0, 1'b1, 32'h0);
        txn(2'b11, 28'h000, 32'h0, 1'b1, 32'h0);
        txn(2'b01, 28'h8000005, 32'hCAFEF00D, 1'b1, 32'h0);
        txn(2'b00, 28'h05,  32'h0, 1'b0, 32'h0);

        // Backpressure on the response while a second request waits
        txn(2'b01, 28'h20, 32'h12345678, 1'b0, 32'h0);
        if1.req_valid = 1'b1; if1.req_op = 2'b00; if1.req_addr = 28'h20;
        step();
        if1.req_addr = 28'h05;
        chk("bp_mem_rd", 32'(if1.mem_rd), 32'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(if1.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", if1.rsp_rdata,      32'h12345678);
            chk("bp_req_ready", 32'(if1.req_ready), 32'd0);
            chk("bp_strobes",   32'({if1.mem_wr, if1.mem_rd, if1.mem_rst}), 32'd0);
            step();
        end
        $display("backpressure read addr=20 rdata=%h held 5 cycles", if1.rsp_rdata);
        if1.rsp_ready = 1'b1;
        step();
        if1.rsp_ready = 1'b0;
        chk("bp_rsp_done",   32'(if1.rsp_valid), 32'd0);
        chk("bp_ready_2nd",  32'(if1.req_ready), 32'd1);
        step();
        if1.req_valid = 1'b0;
        chk("bp_2nd_mem_rd",   32'(if1.mem_rd),      32'd1);
        chk("bp_2nd_mem_addr", 32'(if1.mem_address), 32'h05);
        step();
        chk("bp_2nd_rsp_valid", 32'(if1.rsp_valid), 32'd1);
        chk("bp_2nd_rdata",     if1.rsp_rdata,      32'h0);
        $display("queued read addr=05 rdata=%h", if1.rsp_rdata);
        if1.rsp_ready = 1'b1;
        step();
        if1.rsp_ready = 1'b0;

        // Three-cycle read strobe: value on mem_data1 in the 3rd cycle is taken
        chk("rd3_req_ready", 32'(if3.req_ready), 32'd1);
        if3.req_valid = 1'b1; if3.req_op = 2'b00; if3.req_addr = 28'h42;
        step();
        if3.req_valid = 1'b0;
        if3.mem_data1 = 32'h11111111;
        chk("rd3_c1_mem_rd", 32'(if3.mem_rd), 32'd1);
        chk("rd3_c1_addr",   32'(if3.mem_address), 32'h42);
        step();
        if3.mem_data1 = 32'h22222222;
        chk("rd3_c2_mem_rd",    32'(if3.mem_rd), 32'd1);
        chk("rd3_c2_rsp_valid", 32'(if3.rsp_valid), 32'd0);
        chk("rd3_c2_addr",      32'(if3.mem_address), 32'h42);
        step();
        if3.mem_data1 = 32'h33333333;
        chk("rd3_c3_mem_rd",    32'(if3.mem_rd), 32'd1);
        chk("rd3_c3_rsp_valid", 32'(if3.rsp_valid), 32'd0);
        chk("rd3_c3_addr",      32'(if3.mem_address), 32'h42);
        step();
        if3.mem_data1 = 32'h44444444;
        chk("rd3_c4_mem_rd",    32'(if3.mem_rd), 32'd0);
        chk("rd3_c4_rsp_valid", 32'(if3.rsp_valid), 32'd1);
        chk("rd3_c4_rdata",     if3.rsp_rdata, 32'h33333333);
        chk("rd3_c4_addr",      32'(if3.mem_address), 32'h42);
        $display("rd3 read addr=42 rdata=%h", if3.rsp_rdata);
        if3.rsp_ready = 1'b1;
        step();
        if3.rsp_ready = 1'b0;
        chk("rd3_done", 32'(if3.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
